// File: rtl/mvp_pkg.sv
// Shared types for the mvp bit-plane sequencer: FSM states, pass tag, sum width helper.
package mvp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Wide enough for shift = wb + db with up to 32 planes per operand
    localparam int unsigned SHIFT_W = 6;

    typedef struct packed {
        logic               valid;
        logic               first;
        logic [SHIFT_W-1:0] shift;
        logic               neg;
    } tag_t;

    function automatic int unsigned sum_width(input int unsigned n);
        return $clog2(n) + 2;
    endfunction

endpackage

// File: rtl/mvp_sched_tagq.sv
// Fixed-depth pass-tag delay line; keeps each tag aligned with the mvp sum of its pass.
module mvp_sched_tagq
    import mvp_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic pending
);

    tag_t q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            q[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) q[i] <= q[i-1];
        end
    end

    assign tag_out = q[DEPTH-1];

    // Any tag that will still be in flight after the current output is consumed
    always_comb begin
        pending = tag_in.valid;
        for (int unsigned i = 0; i < DEPTH - 1; i++) pending = pending | q[i].valid;
    end

endmodule

// File: rtl/mvp_sched.sv
// Bit-plane MVM sequencer: issues operand plane reads, tags passes, shift-accumulates mvp sums per lane.
module mvp_sched
    import mvp_pkg::*;
#(
    parameter int unsigned N         = 32,
    parameter int unsigned WPREC_MAX = 8,
    parameter int unsigned DPREC_MAX = 8,
    parameter int unsigned MVP_LAT   = 1,
    parameter int unsigned AW        = 10,
    parameter int unsigned ACCW      = 32,
    localparam int unsigned SW  = sum_width(N),
    localparam int unsigned WPW = $clog2(WPREC_MAX + 1),
    localparam int unsigned DPW = $clog2(DPREC_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WPW-1:0]    cmd_wprec,
    input  logic [DPW-1:0]    cmd_dprec,
    input  logic              cmd_wsign,
    input  logic              cmd_dsign,
    input  logic [1:0]        cmd_mode,
    input  logic [AW-1:0]     cmd_wbase,
    input  logic [AW-1:0]     cmd_dbase,
    output logic              w_rd_en,
    output logic [AW-1:0]     w_rd_addr,
    output logic              d_rd_en,
    output logic [AW-1:0]     d_rd_addr,
    output logic [1:0]        mvp_mode,
    input  logic [N*SW-1:0]   mvp_s,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N*ACCW-1:0] res_data
);

    state_t         state;
    logic [WPW-1:0] wprec_q, wb, wb_nx, wprec_c;
    logic [DPW-1:0] dprec_q, db, db_nx, dprec_c;
    logic           wsign_q, dsign_q;
    logic [AW-1:0]  wbase_q, dbase_q;
    logic           last_pass;
    tag_t           cur_tag, tag_out;
    logic           tag_pending;

    function automatic logic [WPW-1:0] clamp_w(input logic [WPW-1:0] p);
        if (p == '0) return WPW'(1);
        if (p > WPW'(WPREC_MAX)) return WPW'(WPREC_MAX);
        return p;
    endfunction

    function automatic logic [DPW-1:0] clamp_d(input logic [DPW-1:0] p);
        if (p == '0) return DPW'(1);
        if (p > DPW'(DPREC_MAX)) return DPW'(DPREC_MAX);
        return p;
    endfunction

    // MSB plane of a signed operand carries negative weight
    function automatic tag_t make_tag(input logic [WPW-1:0] w, input logic [WPW-1:0] wp,
                                      input logic [DPW-1:0] d, input logic [DPW-1:0] dp,
                                      input logic ws, input logic ds, input logic first);
        tag_t t;
        t.valid = 1'b1;
        t.first = first;
        t.shift = SHIFT_W'(w) + SHIFT_W'(d);
        t.neg   = (ws && (w == wp - WPW'(1))) ^ (ds && (d == dp - DPW'(1)));
        return t;
    endfunction

    // Pass order: data plane inner, weight plane outer
    always_comb begin
        wprec_c   = clamp_w(cmd_wprec);
        dprec_c   = clamp_d(cmd_dprec);
        last_pass = (wb == wprec_q - WPW'(1)) && (db == dprec_q - DPW'(1));
        wb_nx     = wb;
        db_nx     = db + DPW'(1);
        if (db == dprec_q - DPW'(1)) begin
            wb_nx = wb + WPW'(1);
            db_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            w_rd_en   <= 1'b0;
            d_rd_en   <= 1'b0;
            w_rd_addr <= '0;
            d_rd_addr <= '0;
            mvp_mode  <= '0;
            res_valid <= 1'b0;
            wprec_q   <= '0;
            dprec_q   <= '0;
            wsign_q   <= 1'b0;
            dsign_q   <= 1'b0;
            wbase_q   <= '0;
            dbase_q   <= '0;
            wb        <= '0;
            db        <= '0;
            cur_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= ISSUE;
                        cmd_ready <= 1'b0;
                        wprec_q   <= wprec_c;
                        dprec_q   <= dprec_c;
                        wsign_q   <= cmd_wsign;
                        dsign_q   <= cmd_dsign;
                        wbase_q   <= cmd_wbase;
                        dbase_q   <= cmd_dbase;
                        mvp_mode  <= cmd_mode;
                        wb        <= '0;
                        db        <= '0;
                        w_rd_en   <= 1'b1;
                        d_rd_en   <= 1'b1;
                        w_rd_addr <= cmd_wbase;
                        d_rd_addr <= cmd_dbase;
                        cur_tag   <= make_tag('0, wprec_c, '0, dprec_c,
                                              cmd_wsign, cmd_dsign, 1'b1);
                    end
                end
                ISSUE: begin
                    if (last_pass) begin
                        state   <= DRAIN;
                        w_rd_en <= 1'b0;
                        d_rd_en <= 1'b0;
                        cur_tag <= '0;
                    end else begin
                        wb        <= wb_nx;
                        db        <= db_nx;
                        w_rd_addr <= wbase_q + AW'(wb_nx);
                        d_rd_addr <= dbase_q + AW'(db_nx);
                        cur_tag   <= make_tag(wb_nx, wprec_q, db_nx, dprec_q,
                                              wsign_q, dsign_q, 1'b0);
                    end
                end
                DRAIN: begin
                    if (!tag_pending) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mvp_sched_tagq #(
        .DEPTH (1 + MVP_LAT)
    ) u_tagq (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (cur_tag),
        .tag_out (tag_out),
        .pending (tag_pending)
    );

    // Per-lane shift-accumulate at tag exit; wraps mod 2^ACCW
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [SW-1:0]   s;
        logic [ACCW-1:0] term, addend, acc;

        assign s      = mvp_s[i*SW +: SW];
        assign term   = ACCW'(s) << tag_out.shift;
        assign addend = tag_out.neg ? (ACCW'(0) - term) : term;

        always_ff @(posedge clk) begin
            if (rst) begin
                acc <= '0;
            end else if (tag_out.valid) begin
                acc <= tag_out.first ? addend : (acc + addend);
            end
        end

        assign res_data[i*ACCW +: ACCW] = acc;
    end

endmodule

// File: tb/tb_mvp_sched.sv
// Randomized and directed bench for mvp_sched against a plane-sum reference model.
module tb_mvp_sched;

    localparam int unsigned N         = 32;
    localparam int unsigned WPREC_MAX = 8;
    localparam int unsigned DPREC_MAX = 8;
    localparam int unsigned MVP_LAT   = 1;
    localparam int unsigned AW        = 10;
    localparam int unsigned ACCW      = 32;
    localparam int unsigned SW        = $clog2(N) + 2;
    localparam int unsigned WPW       = $clog2(WPREC_MAX + 1);
    localparam int unsigned DPW       = $clog2(DPREC_MAX + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready;
    logic [WPW-1:0]    cmd_wprec;
    logic [DPW-1:0]    cmd_dprec;
    logic              cmd_wsign, cmd_dsign;
    logic [1:0]        cmd_mode;
    logic [AW-1:0]     cmd_wbase, cmd_dbase;
    logic              w_rd_en, d_rd_en;
    logic [AW-1:0]     w_rd_addr, d_rd_addr;
    logic [1:0]        mvp_mode;
    logic [N*SW-1:0]   mvp_s;
    logic              res_valid, res_ready;
    logic [N*ACCW-1:0] res_data;

    int checks   = 0;
    int failures = 0;
    int salt     = 0;
    int pcnt     = 0;
    int wq[$];
    int dq[$];
    logic [SW-1:0] mem_q;
    logic [SW-1:0] pipe [MVP_LAT];

    always #5 clk = ~clk;

    mvp_sched #(
        .N(N), .WPREC_MAX(WPREC_MAX), .DPREC_MAX(DPREC_MAX),
        .MVP_LAT(MVP_LAT), .AW(AW), .ACCW(ACCW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wprec(cmd_wprec), .cmd_dprec(cmd_dprec),
        .cmd_wsign(cmd_wsign), .cmd_dsign(cmd_dsign),
        .cmd_mode(cmd_mode), .cmd_wbase(cmd_wbase), .cmd_dbase(cmd_dbase),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr),
        .mvp_mode(mvp_mode), .mvp_s(mvp_s),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // Memory + mvp stub: the k-th read of a command yields k on lane 0 after the read and mvp latency
    always @(posedge clk) begin
        if (rst || (cmd_valid && cmd_ready)) pcnt <= 0;
        else if (w_rd_en) pcnt <= pcnt + 1;
        mem_q   <= SW'(pcnt + 1);
        pipe[0] <= mem_q;
        for (int k = 1; k < int'(MVP_LAT); k++) pipe[k] <= pipe[k-1];
    end

    always_comb begin
        for (int i = 0; i < int'(N); i++) mvp_s[i*SW +: SW] = pipe[MVP_LAT-1] + SW'(salt * i);
    end

    always @(negedge clk) begin
        if (w_rd_en) wq.push_back(int'(w_rd_addr));
        if (d_rd_en) dq.push_back(int'(d_rd_addr));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int clampv(input int raw, input int mx);
        if (raw == 0) return 1;
        if (raw > mx) return mx;
        return raw;
    endfunction

    // Sum over all plane pairs of +/- 2^(wb+db) * S(pass), truncated to ACCW bits
    function automatic logic [ACCW-1:0] ref_lane(input int wp, input int dp, input bit ws,
                                                 input bit ds, input int slt, input int lane);
        longint acc = 0;
        for (int p = 0; p < wp * dp; p++) begin
            int  wb  = p / dp;
            int  db  = p % dp;
            longint s    = longint'((p + 1 + slt * lane) % (1 << SW));
            longint term = s << (wb + db);
            bit  neg = (ws && wb == wp - 1) ^ (ds && db == dp - 1);
            acc = neg ? acc - term : acc + term;
        end
        return acc[ACCW-1:0];
    endfunction

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({pfx, "_w_rd_en"},   64'(w_rd_en),   64'd0);
        check({pfx, "_d_rd_en"},   64'(d_rd_en),   64'd0);
        check({pfx, "_w_rd_addr"}, 64'(w_rd_addr), 64'd0);
        check({pfx, "_d_rd_addr"}, 64'(d_rd_addr), 64'd0);
        check({pfx, "_mvp_mode"},  64'(mvp_mode),  64'd0);
        check({pfx, "_res_valid"}, 64'(res_valid), 64'd0);
        check({pfx, "_res_zero"},  64'(res_data == '0), 64'd1);
    endtask

    task automatic run_cmd(input int wraw, input int draw, input bit ws, input bit ds,
                           input int mode, input int wbase, input int dbase,
                           input int slt, input int hold, input bit early);
        int wp, dp, k, e;
        logic [ACCW-1:0] exp_l [N];
        wp = clampv(wraw, int'(WPREC_MAX));
        dp = clampv(draw, int'(DPREC_MAX));
        k  = wp * dp;
        for (int i = 0; i < int'(N); i++) exp_l[i] = ref_lane(wp, dp, ws, ds, slt, i);

        @(negedge clk);
        salt = slt;
        wq.delete();
        dq.delete();
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_wprec = WPW'(wraw);
        cmd_dprec = DPW'(draw);
        cmd_wsign = ws;
        cmd_dsign = ds;
        cmd_mode  = 2'(mode);
        cmd_wbase = AW'(wbase);
        cmd_dbase = AW'(dbase);
        cmd_valid = 1'b1;
        res_ready = early;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_wprec = WPW'($urandom);
        cmd_dprec = DPW'($urandom);
        cmd_wsign = 1'($urandom);
        cmd_dsign = 1'($urandom);
        cmd_mode  = 2'($urandom);
        cmd_wbase = AW'($urandom);
        cmd_dbase = AW'($urandom);
        check("busy_cmd_ready", 64'(cmd_ready), 64'd0);

        e = 0;
        while (!res_valid && e < 400) begin
            @(posedge clk);
            #1;
            e++;
        end
        if (!res_valid) begin
            check("res_valid_timeout", 64'(res_valid), 64'd1);
            res_ready = 1'b0;
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            return;
        end

        check("latency", 64'(e), 64'(k + int'(MVP_LAT) + 1));
        check("w_reads", 64'(wq.size()), 64'(k));
        check("d_reads", 64'(dq.size()), 64'(k));
        for (int p = 0; p < k && p < wq.size() && p < dq.size(); p++) begin
            check($sformatf("w_addr%0d", p), 64'(wq[p]), 64'((wbase + p / dp) % (1 << AW)));
            check($sformatf("d_addr%0d", p), 64'(dq[p]), 64'((dbase + p % dp) % (1 << AW)));
        end
        check("mvp_mode", 64'(mvp_mode), 64'(mode));
        for (int i = 0; i < int'(N); i++)
            check($sformatf("lane%0d", i), 64'(res_data[i*ACCW +: ACCW]), 64'(exp_l[i]));

        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                cmd_valid = 1'b1;
                @(posedge clk);
                #1;
                check("hold_res_valid", 64'(res_valid), 64'd1);
                check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
                check("hold_lane0", 64'(res_data[0 +: ACCW]), 64'(exp_l[0]));
                check($sformatf("hold_lane%0d", N - 1),
                      64'(res_data[(N-1)*ACCW +: ACCW]), 64'(exp_l[N-1]));
            end
            cmd_valid = 1'b0;
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("release_res_valid", 64'(res_valid), 64'd0);
        check("release_cmd_ready", 64'(cmd_ready), 64'd1);
        res_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_wprec = '0; cmd_dprec = '0;
        cmd_wsign = 1'b0; cmd_dsign = 1'b0; cmd_mode = '0;
        cmd_wbase = '0; cmd_dbase = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        run_cmd(1, 1, 0, 0, 1, 5, 9, 0, 0, 0);      // single pass
        run_cmd(2, 2, 0, 0, 2, 5, 9, 0, 0, 0);      // 27 on every lane
        run_cmd(2, 2, 1, 1, 3, 5, 9, 0, 0, 0);      // 7
        run_cmd(2, 2, 1, 0, 0, 5, 9, 0, 0, 0);      // -17
        run_cmd(2, 3, 0, 1, 1, 20, 30, 0, 10, 0);   // long stall in DONE
        run_cmd(0, 12, 0, 1, 2, 100, 200, 3, 1, 0); // clamp to 1x8
        run_cmd(2, 1, 1, 0, 3, 1023, 1020, 5, 0, 1); // address wrap, ready held early

        // Abort an 8x8 command on its third pass
        @(negedge clk);
        salt = 0;
        cmd_wprec = WPW'(8); cmd_dprec = DPW'(8);
        cmd_wsign = 1'b1; cmd_dsign = 1'b0; cmd_mode = 2'd3;
        cmd_wbase = AW'(40); cmd_dbase = AW'(50);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("abort");
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (res_valid) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        run_cmd(1, 1, 0, 0, 0, 7, 8, 0, 0, 0);

        for (int r = 0; r < 12; r++) begin
            run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 127)), int'($urandom_range(0, 3)),
                    1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
